// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the single-port memory command.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              halted;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a shared single-port memory with data-stage priority.
// Define MEM_ARB_STARVE_EN to force one fetch transaction after STARVE_LIMIT denied cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk1,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN_IF, OWN_D} owner_t;

  owner_t owner;
  owner_t owner_next;
  logic   if_gnt_c;
  logic   d_gnt_c;
  logic   starve_force;
  logic   if_rv_q;
  logic   d_rv_q;

  // Grants are combinational so a request can transfer in the same cycle it is owned.
  assign if_gnt_c = (owner == OWN_IF) && bus.if_req && !bus.halted;
  assign d_gnt_c  = (owner == OWN_D) && bus.d_req;

`ifdef MEM_ARB_STARVE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             if_denied;

  assign if_denied = bus.if_req && !bus.halted && !if_gnt_c;
  // The cycle that brings the count to the limit hands the next cycle to fetch.
  assign starve_force = if_denied && ((32'(starve_cnt) + 32'd1) >= STARVE_LIMIT);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_gnt_c || bus.halted) begin
      starve_cnt <= '0;
    end else if (if_denied && (32'(starve_cnt) < STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_limit;

  assign unused_limit = ^STARVE_LIMIT;
  assign starve_force = 1'b0;
`endif

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      owner <= IDLE;
    end else begin
      owner <= owner_next;
    end
  end

  always_comb begin
    owner_next = IDLE;
    if (starve_force) begin
      owner_next = OWN_IF;
    end else if (bus.d_req) begin
      owner_next = OWN_D;
    end else if (bus.if_req && !bus.halted) begin
      owner_next = OWN_IF;
    end
  end

  // Memory command follows whichever requester holds the grant this cycle.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = ADDR_W'(0);
    bus.mem_wdata = 32'd0;
    if (d_gnt_c) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (if_gnt_c) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.if_addr;
    end
  end

  // Read data returns one cycle after the granted read; writes return nothing.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      if_rv_q <= 1'b0;
      d_rv_q  <= 1'b0;
    end else begin
      if_rv_q <= if_gnt_c;
      d_rv_q  <= d_gnt_c && !bus.d_we;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.if_rvalid = if_rv_q;
  assign bus.d_rvalid  = d_rv_q;
  assign bus.if_rdata  = if_rv_q ? bus.mem_rdata : 32'd0;
  assign bus.d_rdata   = d_rv_q ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grants/memory command checked per cycle,
// read returns matched against a queue of expected data and arrival cycles.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 10;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk1;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t if_q[$];
  exp_t d_q[$];
  exp_t mon_e;

  bit   [1023:0] written;
  logic [31:0]   wdat [0:1023];

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  always @(posedge clk1) cyc <= cyc + 1;

  function automatic logic [31:0] rom(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(5)) return 32'h0022_2000;
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Memory model: registered read, writes shadow the ROM contents.
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        wdat[bus.mem_addr]    <= bus.mem_wdata;
        written[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= written[bus.mem_addr] ? wdat[bus.mem_addr] : rom(bus.mem_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read-return monitor.
  always @(negedge clk1) begin
    if (bus.if_rvalid) begin
      if (if_q.size() == 0) begin
        check("if_rv_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = if_q.pop_front();
        check("if_rdata", bus.if_rdata, mon_e.data);
        check("if_rv_cyc", 32'(cyc), 32'(mon_e.cyc));
      end
    end else begin
      check("if_rdata_idle", bus.if_rdata, 32'd0);
      if (if_q.size() > 0 && if_q[0].cyc <= cyc) begin
        mon_e = if_q.pop_front();
        check("if_rv_missing", 32'd0, 32'd1);
      end
    end
    if (bus.d_rvalid) begin
      if (d_q.size() == 0) begin
        check("d_rv_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = d_q.pop_front();
        check("d_rdata", bus.d_rdata, mon_e.data);
        check("d_rv_cyc", 32'(cyc), 32'(mon_e.cyc));
      end
    end else begin
      check("d_rdata_idle", bus.d_rdata, 32'd0);
      if (d_q.size() > 0 && d_q[0].cyc <= cyc) begin
        mon_e = d_q.pop_front();
        check("d_rv_missing", 32'd0, 32'd1);
      end
    end
  end

  task automatic drive(input logic ifr, input logic [ADDR_W-1:0] ifa, input logic dr,
                       input logic dwe, input logic [ADDR_W-1:0] da,
                       input logic [31:0] dwd, input logic h);
    bus.if_req  = ifr;
    bus.if_addr = ifa;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    bus.halted  = h;
  endtask

  task automatic next_cycle();
    @(posedge clk1);
    #1;
  endtask

  task automatic push_rd(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + 1;
    if (is_d) d_q.push_back(e);
    else      if_q.push_back(e);
  endtask

  // Sample one cycle's grants and memory command, then advance.
  task automatic cyc_check(input string tag, input logic eif, input logic ed,
                           input logic [ADDR_W-1:0] eaddr, input logic ewe,
                           input logic [31:0] ewd);
    @(negedge clk1);
    check({tag, "_if_gnt"}, 32'(bus.if_gnt), 32'(eif));
    check({tag, "_d_gnt"}, 32'(bus.d_gnt), 32'(ed));
    check({tag, "_mem_en"}, 32'(bus.mem_en), 32'(eif | ed));
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(eaddr));
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'(ewe));
    check({tag, "_mem_wdata"}, bus.mem_wdata, ewd);
    next_cycle();
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    repeat (n) cyc_check("idle", 1'b0, 1'b0, '0, 1'b0, 32'd0);
  endtask

  initial begin
    logic eif;
    logic ed;
    rst = 1'b1;
    drive(1'b1, 10'd4, 1'b1, 1'b0, 10'd2, 32'd0, 1'b0);
    next_cycle();

    // Reset holds everything low even with both requests pending.
    cyc_check("rst", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    cyc_check("rst", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    rst = 1'b0;
    cyc_check("rel0", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    push_rd(1'b1, rom(10'd2));
    cyc_check("rel1", 1'b0, 1'b1, 10'd2, 1'b0, 32'd0);
    idle(2);

    // Fetch only from idle.
    drive(1'b1, 10'd5, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    cyc_check("a0", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    push_rd(1'b0, 32'h0022_2000);
    cyc_check("a1", 1'b1, 1'b0, 10'd5, 1'b0, 32'd0);
    idle(2);

    // Simultaneous requests: data first, fetch after data drops.
    drive(1'b1, 10'd6, 1'b1, 1'b0, 10'd8, 32'd0, 1'b0);
    cyc_check("b0", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    push_rd(1'b1, rom(10'd8));
    cyc_check("b1", 1'b0, 1'b1, 10'd8, 1'b0, 32'd0);
    drive(1'b1, 10'd6, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    cyc_check("b2", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    push_rd(1'b0, rom(10'd6));
    cyc_check("b3", 1'b1, 1'b0, 10'd6, 1'b0, 32'd0);
    idle(2);

    // Data write, then read it back.
    drive(1'b0, '0, 1'b1, 1'b1, 10'd3, 32'h0000_002A, 1'b0);
    cyc_check("c0", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    cyc_check("c1", 1'b0, 1'b1, 10'd3, 1'b1, 32'h0000_002A);
    idle(2);
    drive(1'b0, '0, 1'b1, 1'b0, 10'd3, 32'd0, 1'b0);
    cyc_check("c2", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    push_rd(1'b1, 32'h0000_002A);
    cyc_check("c3", 1'b0, 1'b1, 10'd3, 1'b0, 32'd0);
    idle(2);

    // Sustained data reads: one grant per cycle.
    drive(1'b0, '0, 1'b1, 1'b0, 10'd10, 32'd0, 1'b0);
    cyc_check("d0", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    for (int k = 10; k <= 12; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 10'(k), 32'd0, 1'b0);
      push_rd(1'b1, rom(10'(k)));
      cyc_check("d_seq", 1'b0, 1'b1, 10'(k), 1'b0, 32'd0);
    end
    idle(2);

    // Halt right after a fetch grant: grant blocked, pending read still returns.
    drive(1'b1, 10'd7, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    cyc_check("e0", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    push_rd(1'b0, rom(10'd7));
    cyc_check("e1", 1'b1, 1'b0, 10'd7, 1'b0, 32'd0);
    drive(1'b1, 10'd7, 1'b0, 1'b0, '0, 32'd0, 1'b1);
    repeat (10) cyc_check("e_halt", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    drive(1'b1, 10'd7, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    cyc_check("e2", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    push_rd(1'b0, rom(10'd7));
    cyc_check("e3", 1'b1, 1'b0, 10'd7, 1'b0, 32'd0);
    idle(2);

    // Both requests held: fetch starves unless the starvation guard is built in.
    drive(1'b1, 10'd21, 1'b1, 1'b0, 10'd20, 32'd0, 1'b0);
    for (int i = 0; i < 12; i++) begin
`ifdef MEM_ARB_STARVE_EN
      eif = (i == 4) || (i == 9);
`else
      eif = 1'b0;
`endif
      ed = (i != 0) && !eif;
      if (eif) push_rd(1'b0, rom(10'd21));
      if (ed)  push_rd(1'b1, rom(10'd20));
      cyc_check("f", eif, ed, eif ? 10'd21 : (ed ? 10'd20 : 10'd0), 1'b0, 32'd0);
    end
    idle(3);

    // Reset during an in-flight data read discards the return.
    drive(1'b0, '0, 1'b1, 1'b0, 10'd9, 32'd0, 1'b0);
    cyc_check("g0", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    cyc_check("g1", 1'b0, 1'b1, 10'd9, 1'b0, 32'd0);
    rst = 1'b1;
    @(negedge clk1);
    check("g_rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("g_rst_d_rdata", bus.d_rdata, 32'd0);
    check("g_rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("g_rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("g_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    next_cycle();
    cyc_check("g_rst", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    rst = 1'b0;
    cyc_check("g_rel0", 1'b0, 1'b0, '0, 1'b0, 32'd0);
    push_rd(1'b1, rom(10'd9));
    cyc_check("g_rel1", 1'b0, 1'b1, 10'd9, 1'b0, 32'd0);
    idle(3);

    check("if_q_empty", 32'(if_q.size()), 32'd0);
    check("d_q_empty", 32'(d_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
